// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues ready-handshake fetches and loads
// the IF/ID register, redirecting and squashing wrong-path fetches on a taken branch.
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [31:0]     NOP       = 32'h0000_0013;
    localparam logic [XLEN-1:0] WORD_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'd4};

    logic [1:0]      state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] redir_pc_reg;
    logic [XLEN-1:0] hold_pc_reg;
    logic [31:0]     hold_instr_reg;

    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] hold_pc_inc;

    assign target_pc   = branch_target & WORD_MASK;
    assign pc_inc      = pc_reg + PC_STEP;
    assign hold_pc_inc = hold_pc_reg + PC_STEP;

    // Gated by rst so the request drops the instant reset is asserted.
    assign imem_req  = !rst && (state_reg == S_REQ || state_reg == S_DROP);
    assign imem_addr = pc_reg & WORD_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC & WORD_MASK;
            redir_pc_reg   <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= '0;
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instr       <= NOP;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (branch) begin
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            pc_reg <= target_pc;
                        end else begin
                            // Fetch still in flight: remember target, drain the old response.
                            redir_pc_reg <= target_pc;
                            state_reg    <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            hold_instr_reg <= imem_rdata;
                            hold_pc_reg    <= pc_reg;
                            state_reg      <= S_HOLD;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= pc_reg;
                            if_instr <= imem_rdata;
                            pc_reg   <= pc_inc;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (branch) begin
                        pc_reg    <= target_pc;
                        if_valid  <= 1'b0;
                        state_reg <= S_REQ;
                    end else if (!stall) begin
                        if_valid  <= 1'b1;
                        if_pc     <= hold_pc_reg;
                        if_instr  <= hold_instr_reg;
                        pc_reg    <= hold_pc_inc;
                        state_reg <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (branch || !stall) begin
                        if_valid <= 1'b0;
                    end
                    if (imem_ready) begin
                        pc_reg    <= branch ? target_pc : redir_pc_reg;
                        state_reg <= S_REQ;
                    end else if (branch) begin
                        redir_pc_reg <= target_pc;
                    end
                end
                default: begin
                    state_reg <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the branching unit's consumer path. Holds the PC and issues requests on a ready-handshake instruction memory port.
- Drives the IF/ID pipeline register: if_valid, if_pc, if_instr.
- On a taken-branch decision (branch from branching_unit, with target from the EX adder) it redirects the PC and squashes the wrong-path fetch, including a fetch already in flight.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; the IF/ID register must hold.
- branch  input  1  final taken-branch decision from branching_unit.
- branch_target  input  XLEN  redirect address, valid when branch=1.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address; bits [1:0] always 0.
- imem_ready  input  1  memory returns imem_rdata for imem_addr this cycle.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_pc  output  XLEN  PC of if_instr.
- if_instr  output  32  fetched instruction.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Registers: pc, redir_pc, hold_instr, hold_pc, state (S_REQ, S_HOLD, S_DROP), and the IF/ID register.
- Reset values:
  - state=S_REQ, pc=RESET_PC, redir_pc=0, hold_*=0.
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
  - imem_req=0 while rst=1.
- Address rules:
  - imem_addr = {pc[XLEN-1:2],2'b00}.
  - Sequential PC = pc+4, wrapping modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0.
  - branch_target[1:0] is ignored (forced to 00).
- Memory handshake:
  - imem_req=1 in S_REQ and S_DROP; imem_req=0 in S_HOLD.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - A response is accepted in the cycle imem_ready=1.
- Latency: a response accepted at edge N appears on if_valid/if_instr after edge N.
- Priority: branch > stall > normal flow, in every state.
- S_REQ:
  - branch=1, imem_ready=1: response discarded; pc<=target; stay in S_REQ; if_valid<=0.
  - branch=1, imem_ready=0: redir_pc<=target; go to S_DROP; if_valid<=0.
  - imem_ready=1, stall=0: if_valid<=1, if_pc<=pc, if_instr<=rdata; pc<=pc+4; stay in S_REQ.
  - imem_ready=1, stall=1: hold_instr<=rdata, hold_pc<=pc; go to S_HOLD; IF/ID unchanged.
  - imem_ready=0, stall=0: if_valid<=0 (bubble).
  - imem_ready=0, stall=1: IF/ID unchanged.
- S_HOLD:
  - branch=1: buffer dropped; pc<=target; if_valid<=0; go to S_REQ.
  - stall=0: IF/ID<=hold buffer (if_valid<=1); pc<=hold_pc+4; go to S_REQ.
  - otherwise: hold everything.
- S_DROP:
  - Keeps requesting the old pc until imem_ready; that response is always discarded.
  - A branch in S_DROP overwrites redir_pc.
  - On imem_ready: pc<=(branch ? target : redir_pc); go to S_REQ.
  - if_valid<=0 on every cycle with stall=0; IF/ID holds when stall=1 and branch=0.
- Back-to-back: with imem_ready tied high and no stall or branch, one instruction is delivered per cycle.
- Reset mid-operation: immediately returns to the reset values. An outstanding memory response is abandoned; the memory model must tolerate the request being dropped.
- No X propagation: if_instr changes only on an accepted, non-discarded response.

Test Plan:
- Reset, imem_ready=1, addr→word = {addr,2'b11} truncated to 32 bits → imem_addr sequence 0,4,8,C; if_pc 0,4,8 one cycle behind; if_valid=1 from the second edge.
- imem_ready low 3 cycles at addr 8, stall=0 → imem_addr held at 8; if_valid=0 for 3 cycles; then if_pc=8.
- stall=1 on the cycle 0x10 returns, held 2 cycles → imem_req=0; IF/ID keeps 0xC; after release if_pc=0x10, next imem_addr=0x14.
- branch=1, target=0x100, while 0x14 is pending (ready low 2 more cycles) → S_DROP; the 0x14 data is never presented; next imem_addr=0x100; if_valid=0 until if_pc=0x100.
- branch=1 with target=0x203 during S_HOLD, stall still 1 → hold buffer dropped; imem_addr=0x200; if_valid=0.
- pc=32'hFFFF_FFFC fetched, then wrap → next imem_addr=0. Separately, assert rst mid-request at pc=0x40 → outputs return to reset values immediately; first fetch after reset is RESET_PC.
